// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: op encodings and FSM states for the MIPS multiply/divide unit.
// The DIV state exists only when MIPS_MULDIV_DIV_EN is defined.
package mips_muldiv_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX
`ifdef MIPS_MULDIV_DIV_EN
    , DIV
`endif
  } state_t;
endpackage

// File: rtl/mips_muldiv_unit_step.sv
// muldiv_step: one combinational iteration, shift-add for multiply or restoring
// trial-subtract-shift for divide, over a 2*WIDTH accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Partial remainder with the next dividend bit shifted in, minus divisor.
    trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_nxt = !is_div   ? {sum, acc[WIDTH-1:1]} :
              trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                             {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, MTHI/MTLO and MFHI/MFLO reads.
// Divide support is compiled in only when MIPS_MULDIV_DIV_EN is defined.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  input  logic             mf_hi,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz,
  output logic             illegal
);
  localparam int W2 = 2 * WIDTH;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d, acc_nxt, prod;
  logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
  logic             neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, zero_q, zero_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ill_q, ill_d;
  logic             is_mul, is_div, sgn, a_neg, b_neg;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .acc    (acc_q),
    .opnd   (opnd_q),
    .acc_nxt(acc_nxt)
  );

  always_comb begin
    is_mul  = op == OP_MULT || op == OP_MULTU;
    is_div  = op == OP_DIV || op == OP_DIVU;
    sgn     = op == OP_MULT || op == OP_DIV;
    a_neg   = sgn & a[WIDTH-1];
    b_neg   = sgn & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    // Sign fix-up applied in FIX; a zero divisor forces LO to all ones and
    // leaves the shifted-through dividend (re-signed) in HI.
    prod    = neg_q ? -acc_q : acc_q;
    quo     = zero_q ? '1 : neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ill_d   = 1'b0;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (is_mul || is_div) begin
          acc_d  = {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
          opnd_d = is_mul ? a_mag : b_mag;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          zero_d = is_div & ~|b;
          cnt_d  = '0;
`ifdef MIPS_MULDIV_DIV_EN
          div_d  = is_div;
`else
          div_d  = 1'b0;
`endif
        end
        if (is_mul) state_d = MUL;
`ifdef MIPS_MULDIV_DIV_EN
        if (is_div) state_d = DIV;
`else
        if (is_div) ill_d = 1'b1;
`endif
        if (op == OP_MTHI) hi_d = a;
        if (op == OP_MTLO) lo_d = a;
      end
`ifdef MIPS_MULDIV_DIV_EN
      MUL, DIV: begin
`else
      MUL: begin
`endif
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        hi_d    = div_q ? rem : prod[W2-1:WIDTH];
        lo_d    = div_q ? quo : prod[WIDTH-1:0];
        dbz_d   = zero_q;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
    end
  end

  assign rdata   = mf_hi ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = busy_q;
  assign stall   = busy_q & (start | mf_req);
  assign done    = done_q;
  assign dbz     = dbz_q;
  assign illegal = ill_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: randomized and directed checks of mips_muldiv_unit against a
// 64-bit arithmetic reference model; divide tests follow MIPS_MULDIV_DIV_EN.
module tb_mips_muldiv_unit;
  localparam logic [2:0] T_MULT = 3'd1, T_MULTU = 3'd2, T_DIV = 3'd3, T_DIVU = 3'd4;
  localparam logic [2:0] T_MTHI = 3'd5, T_MTLO = 3'd6;
  logic        clk = 1'b0;
  logic        reset, start, mf_req, mf_hi;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] rdata, hi, lo;
  logic        busy, stall, done, dbz, illegal;
  logic [31:0] exp_hi, exp_lo;
  int          errors = 0;
  int          checks = 0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mf_req(mf_req), .mf_hi(mf_hi), .rdata(rdata), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .done(done), .dbz(dbz), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] o, input logic [31:0] x, y,
                                output logic [31:0] h, l, output logic z);
    longint     sx, sy;
    logic [63:0] p;
    bit         sg;
    sg = (o == T_MULT) || (o == T_DIV);
    sx = sg ? longint'($signed(x)) : longint'(x);
    sy = sg ? longint'($signed(y)) : longint'(y);
    z  = 1'b0;
    if (o == T_MULT || o == T_MULTU) begin
      p = 64'(sx * sy);
      h = p[63:32];
      l = p[31:0];
    end else if (y == 32'd0) begin
      h = x;
      l = 32'hFFFF_FFFF;
      z = 1'b1;
    end else begin
      l = 32'(sx / sy);
      h = 32'(sx % sy);
    end
  endfunction

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 5);
    if (s == 0) return 32'h8000_0000;
    if (s == 1) return 32'hFFFF_FFFF;
    if (s == 2) return 32'd0;
    return $urandom;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, y, input string nm);
    logic [31:0] eh, el;
    logic        ez;
    int          n;
    bit          busy_bad;
    model(o, x, y, eh, el, ez);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    n = 1;
    busy_bad = 1'b0;
    while (!done && n < 100) begin
      if (!busy) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done || n != 34) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (done=%b), want 34", nm, n, done);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy: dropped before done, want high throughout", nm);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_with_done: got busy=%b, want 0", nm, busy);
    end
    checks++;
    if (hi !== eh || lo !== el || dbz !== ez) begin
      errors++;
      $display("FAIL %s op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
               nm, o, x, y, hi, lo, dbz, eh, el, ez);
    end
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: got done=%b dbz=%b one cycle later, want 0 0", nm, done, dbz);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; mf_req = 1'b0; mf_hi = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hi, lo, rdata, busy, stall, done, dbz, illegal} !== '0) begin
      errors++;
      $display("FAIL reset: got hi=%h lo=%h rdata=%h busy=%b stall=%b done=%b dbz=%b illegal=%b, want all 0",
               hi, lo, rdata, busy, stall, done, dbz, illegal);
    end
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    do_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_max_const: got hi=%h lo=%h, want fffffffe 00000001", hi, lo);
    end
    do_op(T_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg_const: got hi=%h lo=%h, want ffffffff ffffffeb", hi, lo);
    end
    do_op(T_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    do_op(T_MULT, 32'h8000_0000, 32'hFFFF_FFFF, "mult_min_m1");
  endtask

`ifdef MIPS_MULDIV_DIV_EN
  task automatic test_div();
    do_op(T_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg_const: got hi=%h lo=%h, want ffffffff fffffffd", hi, lo);
    end
    do_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    do_op(T_DIVU, 32'd5, 32'd0, "divu_zero");
    do_op(T_DIV, 32'hFFFF_FFF0, 32'd0, "div_zero_neg");
    do_op(T_DIVU, 32'hFFFF_FFFF, 32'd7, "divu_big");
    do_op(T_DIV, 32'd17, 32'hFFFF_FFFB, "div_pos_neg");
  endtask
`else
  task automatic test_illegal();
    @(negedge clk);
    start = 1'b1; op = T_DIV; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    checks++;
    if (illegal !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: got illegal=%b busy=%b done=%b, want 1 0 0", illegal, busy, done);
    end
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || hi !== exp_hi || lo !== exp_lo || dbz !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after: got illegal=%b hi=%h lo=%h dbz=%b, want 0 %h %h 0",
               illegal, hi, lo, dbz, exp_hi, exp_lo);
    end
  endtask
`endif

  task automatic test_stall();
    logic [31:0] x, y, eh, el;
    logic        ez;
    int          n;
    bit          bad;
    x = $urandom; y = $urandom;
    model(T_MULT, x, y, eh, el, ez);
    @(negedge clk);
    start = 1'b1; op = T_MULT; a = x; b = y;
    @(negedge clk);
    op = T_MTHI; a = 32'hDEAD_BEEF; mf_req = 1'b1; mf_hi = 1'b0;
    #1;
    n = 0;
    bad = 1'b0;
    while (!done && n < 100) begin
      if (!stall || !busy) bad = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    start = 1'b0; op = 3'd0;
    #1;
    checks++;
    if (bad || !done) begin
      errors++;
      $display("FAIL stall_inflight: stall dropped or no done (done=%b after %0d cycles), want stall until done", done, n);
    end
    checks++;
    if (stall !== 1'b0 || rdata !== el || hi !== eh) begin
      errors++;
      $display("FAIL stall_read: got stall=%b rdata=%h hi=%h, want 0 %h %h", stall, rdata, hi, el, eh);
    end
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    mf_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2, h1, l1, h2, l2;
    logic        z1, z2;
    int          n;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    model(T_MULTU, x1, y1, h1, l1, z1);
    model(T_MULT, x2, y2, h2, l2, z2);
    @(negedge clk);
    start = 1'b1; op = T_MULTU; a = x1; b = y1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != 34 || hi !== h1 || lo !== l1) begin
      errors++;
      $display("FAIL b2b_first: got n=%0d hi=%h lo=%h, want 34 %h %h", n, hi, lo, h1, l1);
    end
    start = 1'b1; op = T_MULT; a = x2; b = y2;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    n = 1;
    while (!done && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != 34 || hi !== h2 || lo !== l2) begin
      errors++;
      $display("FAIL b2b_second: got n=%0d hi=%h lo=%h, want 34 %h %h", n, hi, lo, h2, l2);
    end
    exp_hi = h2;
    exp_lo = l2;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
`ifdef MIPS_MULDIV_DIV_EN
      o = 3'($urandom_range(1, 4));
`else
      o = 3'($urandom_range(1, 2));
`endif
      x = pick();
      y = pick();
      do_op(o, x, y, "random");
    end
  endtask

  task automatic test_mt_mf();
    logic [31:0] v;
    @(negedge clk);
    start = 1'b1; op = T_MTHI; a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0; op = 3'd0; mf_req = 1'b1; mf_hi = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'h0000_1234 || stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mthi_read: got rdata=%h stall=%b busy=%b done=%b, want 00001234 0 0 0",
               rdata, stall, busy, done);
    end
    v = $urandom | 32'd1;
    @(negedge clk);
    start = 1'b1; op = T_MTLO; a = v; mf_req = 1'b0;
    @(negedge clk);
    start = 1'b0; op = 3'd0; mf_req = 1'b1; mf_hi = 1'b0;
    #1;
    checks++;
    if (rdata !== v || hi !== 32'h0000_1234 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_read: got rdata=%h hi=%h stall=%b, want %h 00001234 0", rdata, hi, stall, v);
    end
    exp_hi = 32'h0000_1234;
    exp_lo = v;
    @(negedge clk);
    mf_req = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit bad;
    @(negedge clk);
    start = 1'b1;
`ifdef MIPS_MULDIV_DIV_EN
    op = T_DIVU;
`else
    op = T_MULTU;
`endif
    a = $urandom; b = $urandom | 32'd1;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL abort_pre: got busy=%b hi=%h lo=%h, want 1 %h %h", busy, hi, lo, exp_hi, exp_lo);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL abort_now: got busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || hi != 32'd0 || lo != 32'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_after: saw done/busy or nonzero HI/LO after reset, want none");
    end
    exp_hi = '0;
    exp_lo = '0;
  endtask

  initial begin
    test_reset();
    test_mul();
`ifdef MIPS_MULDIV_DIV_EN
    test_div();
`else
    test_illegal();
`endif
    test_stall();
    test_back_to_back();
    test_random();
    test_mt_mf();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
